// File: rtl/dmem_arbiter.sv
// Shares the MEM-stage data memory between the pipeline (fixed priority) and a
// DMA/debug port. Each access is arbitrate/latch, drive memory, respond.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  P_MemRead,
  input  logic                  P_MemWrite,
  input  logic [ADDR_WIDTH-1:0] P_Address,
  input  logic [DATA_WIDTH-1:0] P_WriteData,
  output logic [DATA_WIDTH-1:0] P_ReadData,
  output logic                  P_Stall,
  input  logic                  D_Req,
  input  logic                  D_Write,
  input  logic [ADDR_WIDTH-1:0] D_Address,
  input  logic [DATA_WIDTH-1:0] D_WriteData,
  output logic [DATA_WIDTH-1:0] D_ReadData,
  output logic                  D_Ack,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_WriteData,
  output logic                  Mem_MemWrite,
  output logic                  Mem_MemRead,
  input  logic [DATA_WIDTH-1:0] Mem_ReadData
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, SERVE_P, SERVE_D, RESP_P, RESP_D} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [DATA_WIDTH-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic                  p_req;

  assign p_req = P_MemRead | P_MemWrite;

  // The memory-side registers double as the grant latch, so in-flight accesses
  // are immune to requester input changes after the grant edge.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    p_rdata_d   = p_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (D_Req && (!p_req || wait_cnt_q == LIMIT_C)) begin
          state_d     = SERVE_D;
          mem_addr_d  = D_Address;
          mem_wdata_d = D_WriteData;
          mem_we_d    = D_Write;
          mem_re_d    = ~D_Write;
          wait_cnt_d  = '0;
        end else if (p_req) begin
          state_d     = SERVE_P;
          mem_addr_d  = P_Address;
          mem_wdata_d = P_WriteData;
          mem_we_d    = P_MemWrite;
          mem_re_d    = ~P_MemWrite;
          if (D_Req && wait_cnt_q < LIMIT_C) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
      end
      SERVE_P, SERVE_D: begin
        if (mem_re_q) begin
          if (state_q == SERVE_P) begin
            p_rdata_d = Mem_ReadData;
          end else begin
            d_rdata_d = Mem_ReadData;
          end
        end
        d_ack_d     = (state_q == SERVE_D);
        state_d     = (state_q == SERVE_P) ? RESP_P : RESP_D;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
      end
      RESP_P, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      p_rdata_q   <= p_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_ack_q     <= d_ack_d;
    end
  end

  // The pipeline advances on the edge closing RESP_P, so stall drops there.
  assign P_Stall       = p_req && (state_q != RESP_P) && !reset;
  assign P_ReadData    = p_rdata_q;
  assign D_ReadData    = d_rdata_q;
  assign D_Ack         = d_ack_q;
  assign Mem_Address   = mem_addr_q;
  assign Mem_WriteData = mem_wdata_q;
  assign Mem_MemWrite  = mem_we_q;
  assign Mem_MemRead   = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts the
// memory-bus order, read data and stall length; a negedge monitor checks them.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        P_MemRead = 1'b0, P_MemWrite = 1'b0;
  logic [31:0] P_Address = '0, P_WriteData = '0;
  logic [31:0] P_ReadData;
  logic        P_Stall;
  logic        D_Req = 1'b0, D_Write = 1'b0;
  logic [31:0] D_Address = '0, D_WriteData = '0;
  logic [31:0] D_ReadData;
  logic        D_Ack;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Mem_MemWrite, Mem_MemRead;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .P_MemRead(P_MemRead), .P_MemWrite(P_MemWrite), .P_Address(P_Address),
    .P_WriteData(P_WriteData), .P_ReadData(P_ReadData), .P_Stall(P_Stall),
    .D_Req(D_Req), .D_Write(D_Write), .D_Address(D_Address),
    .D_WriteData(D_WriteData), .D_ReadData(D_ReadData), .D_Ack(D_Ack),
    .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
    .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
    .Mem_ReadData(Mem_ReadData)
  );

  always #5 clk = ~clk;

  // Stand-in for data_memory: combinational read, write on the rising edge.
  logic [31:0] ram [0:63];
  assign Mem_ReadData = ram[Mem_Address[7:2]];
  always @(posedge clk) if (Mem_MemWrite && !reset) ram[Mem_Address[7:2]] <= Mem_WriteData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic we;} mem_exp_t;
  typedef struct packed {logic [31:0] rdata; logic [31:0] stall;} p_exp_t;
  mem_exp_t    mem_q[$];
  p_exp_t      p_q[$];
  logic [31:0] d_q[$];

  int n_vec = 0, n_miss = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: memory image, pending requests, P wins since D began waiting.
  logic [31:0] model_mem [0:63];
  bit          p_pend = 0, d_pend = 0;
  int          p_issue = 0, starve = 0;
  logic [31:0] p_rd_m = '0, d_rd_m = '0;

  task automatic applyStimulus(input bit new_p, input bit p_rd, input bit p_wr,
                               input logic [31:0] pa, input logic [31:0] pd,
                               input bit new_d, input bit dw,
                               input logic [31:0] da, input logic [31:0] dd);
    if (new_p && !p_pend && (p_rd || p_wr)) begin
      P_MemRead = p_rd; P_MemWrite = p_wr; P_Address = pa; P_WriteData = pd;
      p_pend = 1; p_issue = cyc;
    end
    if (new_d && !d_pend) begin
      D_Req = 1'b1; D_Write = dw; D_Address = da; D_WriteData = dd;
      d_pend = 1;
    end
    if (!p_pend && !d_pend) begin
      @(posedge clk); #1;
      return;
    end
    if (d_pend && (!p_pend || starve == LIMIT)) begin
      starve = 0;
      mem_q.push_back(mem_exp_t'{D_Address, D_WriteData, D_Write});
      if (D_Write) model_mem[D_Address[7:2]] = D_WriteData;
      else d_rd_m = model_mem[D_Address[7:2]];
      d_q.push_back(d_rd_m);
      repeat (3) @(posedge clk);
      #1;
      D_Req = 1'b0; d_pend = 0;
    end else begin
      if (d_pend && starve < LIMIT) starve++;
      mem_q.push_back(mem_exp_t'{P_Address, P_WriteData, P_MemWrite});
      if (P_MemWrite) model_mem[P_Address[7:2]] = P_WriteData;
      else p_rd_m = model_mem[P_Address[7:2]];
      p_q.push_back(p_exp_t'{p_rd_m, 32'(cyc + 2 - p_issue)});
      repeat (3) @(posedge clk);
      #1;
      P_MemRead = 1'b0; P_MemWrite = 1'b0; p_pend = 0;
    end
  endtask

  mem_exp_t    mon_m;
  p_exp_t      mon_p;
  logic [31:0] mon_d;
  int          stall_cnt = 0, d_ack_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
    end else begin
      if (Mem_MemWrite || Mem_MemRead) begin
        if (mem_q.size() == 0) checkOutput("spurious_mem_access", 1, 0);
        else begin
          mon_m = mem_q.pop_front();
          checkOutput("mem_addr", Mem_Address, mon_m.addr);
          checkOutput("mem_we", Mem_MemWrite, mon_m.we);
          checkOutput("mem_re", Mem_MemRead, !mon_m.we);
          if (mon_m.we) checkOutput("mem_wdata", Mem_WriteData, mon_m.wdata);
        end
      end
      if (D_Ack) begin
        d_ack_cnt++;
        if (d_q.size() == 0) checkOutput("spurious_d_ack", 1, 0);
        else begin
          mon_d = d_q.pop_front();
          checkOutput("d_rdata", D_ReadData, mon_d);
        end
      end
      if (P_MemRead || P_MemWrite) begin
        if (P_Stall) stall_cnt++;
        else if (p_q.size() == 0) checkOutput("spurious_p_done", 1, 0);
        else begin
          mon_p = p_q.pop_front();
          checkOutput("p_rdata", P_ReadData, mon_p.rdata);
          checkOutput("p_stall_cycles", stall_cnt, mon_p.stall);
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acks_before;
    logic [31:0] ra, rd2, ra2, rd3;
    int op;
    for (int i = 0; i < 64; i++) begin ram[i] = '0; model_mem[i] = '0; end
    reset = 1'b0;
    #1 reset = 1'b1;
    #7;
    checkOutput("rst_p_rdata", P_ReadData, 0);
    checkOutput("rst_d_rdata", D_ReadData, 0);
    checkOutput("rst_mem_addr", Mem_Address, 0);
    checkOutput("rst_mem_wdata", Mem_WriteData, 0);
    checkOutput("rst_ctrl", {Mem_MemWrite, Mem_MemRead, D_Ack, P_Stall}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_ctrl", {Mem_MemWrite, Mem_MemRead, D_Ack, P_Stall}, 0);
      checkOutput("idle_addr", Mem_Address, 0);
    end
    @(posedge clk); #1;

    applyStimulus(1, 0, 1, 32'd4, 32'h12345678, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'd4, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'd4, 32'h0);
    applyStimulus(1, 1, 0, 32'd16, 0, 1, 0, 32'd4, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 0, 32'(k * 4), 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'd12, 32'hA5A5A5A5, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'd12, 32'h0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 2);
      ra  = 32'($urandom_range(0, 63)) << 2;
      rd2 = $urandom;
      ra2 = 32'($urandom_range(0, 63)) << 2;
      rd3 = $urandom;
      applyStimulus($urandom_range(0, 99) < 65, op != 1, op != 0, ra, rd2,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1, ra2, rd3);
    end
    while (p_pend || d_pend) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    D_Req = 1'b1; D_Write = 1'b1; D_Address = 32'd8; D_WriteData = 32'hDEADBEEF;
    @(posedge clk); #2;
    checkOutput("serve_d_we", Mem_MemWrite, 1);
    checkOutput("serve_d_addr", Mem_Address, 8);
    reset = 1'b1;
    #1;
    checkOutput("midrst_mem_we", Mem_MemWrite, 0);
    checkOutput("midrst_p_rdata", P_ReadData, 0);
    checkOutput("midrst_d_rdata", D_ReadData, 0);
    D_Req = 1'b0;
    acks_before = d_ack_cnt;
    starve = 0; p_rd_m = '0; d_rd_m = '0;
    @(negedge clk); @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no_ack_after_reset", d_ack_cnt, acks_before);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'd8, 0);
    applyStimulus(1, 1, 0, 32'd8, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    checkOutput("mem_q_drained", mem_q.size(), 0);
    checkOutput("p_q_drained", p_q.size(), 0);
    checkOutput("d_q_drained", d_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the MEM-stage data memory (data_memory) between two requesters: the pipeline MEM stage and a DMA/debug port.
- The pipeline has fixed priority; the DMA port is protected from starvation by a wait counter.
- Each access is three cycles: arbitrate/latch, drive memory, respond. Read data is registered.
- Sits between EX/MEM pipeline register outputs and data_memory; P_Stall feeds the hazard unit.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending DMA request wins (must be >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
P_MemRead  in  1  pipeline load request
P_MemWrite  in  1  pipeline store request
P_Address  in  ADDR_WIDTH  pipeline byte address
P_WriteData  in  DATA_WIDTH  pipeline store data
P_ReadData  out  DATA_WIDTH  registered pipeline load data
P_Stall  out  1  hold pipeline; combinational
D_Req  in  1  DMA request, held until D_Ack
D_Write  in  1  DMA op: 1 = write, 0 = read
D_Address  in  ADDR_WIDTH  DMA address
D_WriteData  in  DATA_WIDTH  DMA write data
D_ReadData  out  DATA_WIDTH  registered DMA read data
D_Ack  out  1  one-cycle completion pulse
Mem_Address  out  ADDR_WIDTH  to data_memory Address
Mem_WriteData  out  DATA_WIDTH  to data_memory WriteData
Mem_MemWrite  out  1  to data_memory MemWrite
Mem_MemRead  out  1  to data_memory MemRead
Mem_ReadData  in  DATA_WIDTH  from data_memory ReadData

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high. Reset forces state IDLE and clears all registers immediately.
- Reset values: P_ReadData=0, D_ReadData=0, D_Ack=0, Mem_Address=0, Mem_WriteData=0, Mem_MemWrite=0, Mem_MemRead=0, P_Stall=0, starvation counter=0.
- P request: PR = P_MemRead | P_MemWrite. If both are high, it is a write and Mem_MemRead stays 0.
- States: IDLE, SERVE_P, SERVE_D, RESP_P, RESP_D.
- IDLE: grant D if D_Req && (!PR || wait_cnt==STARVE_LIMIT). Otherwise grant P if PR. Otherwise stay in IDLE.
  - On grant, latch address, write data and op into internal registers.
  - Go to SERVE_P or SERVE_D on the next edge.
- SERVE_x: drive Mem_* from the latched registers. Mem_MemWrite or Mem_MemRead is high for exactly this one cycle.
  - At the closing edge, capture Mem_ReadData into the granted port's ReadData register (reads only; write leaves it unchanged), then go to RESP_x.
- RESP_P / RESP_D: Mem_MemRead, Mem_MemWrite and Mem_Address return to 0.
  - RESP_D: D_Ack=1. The next state is always IDLE.
  - Any request seen in IDLE afterwards is a new transaction, including a D_Req still high the cycle after D_Ack.
- P_Stall = PR && state!=RESP_P && !reset. The pipeline advances on the edge that closes RESP_P, so a P access costs 2 stall cycles when uncontended.
- Starvation counter wait_cnt:
  - Increments, saturating at STARVE_LIMIT, on each IDLE grant to P while D_Req is high.
  - Clears on any grant to D.
- Requesters must keep inputs stable until completion. Inputs are latched at grant, so later changes do not affect the in-flight access.
- Reset mid-access: Mem_MemWrite and Mem_MemRead drop in the same instant reset rises. The access is abandoned, no D_Ack is issued and no ReadData register is updated.

Test Plan:
- Reset with all inputs 0 -> every output 0 and state IDLE; release reset with no requests -> outputs stay 0 for 5 cycles.
- P_MemWrite=1, P_Address=4, P_WriteData=0x12345678 -> P_Stall high 2 cycles; Mem_MemWrite high exactly 1 cycle with Mem_Address=4; P_Stall low in the third cycle. Follow with P_MemRead at addr 4 -> P_ReadData=0x12345678 in RESP_P.
- D_Req=1, D_Write=0, D_Address=4 while P idle -> D_Ack pulses once, 2 cycles after request; D_ReadData=0x12345678 (after the previous write).
- D_Req and PR rise together, STARVE_LIMIT=4, P requests continuous -> P served 4 times, D granted on the 5th arbitration, wait_cnt returns to 0, and P_Stall stays high during D service.
- Reset asserted mid-cycle during SERVE_D write (addr 8, data 0xDEADBEEF) -> Mem_MemWrite falls with reset, no D_Ack, and P_ReadData/D_ReadData return to 0.
- P_MemRead=1 and P_MemWrite=1, addr 12, data 0xA5A5A5A5 -> write-only access, Mem_MemRead never high; a later read of 12 returns 0xA5A5A5A5.
